// File: rtl/pcihellocore_pio_pkg.sv
// Shared constants for the PIO output block: register offsets, pulse FSM
// encoding and the STATUS word packing.
package pcihellocore_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE     = 3'd6;
  localparam logic [2:0] ADDR_STATUS    = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_e;

  // STATUS: remaining count in [31:16], busy in bit 0.
  function automatic logic [31:0] status_word(input logic busy, input logic [15:0] count);
    return {count, 15'b0, busy};
  endfunction

endpackage

// File: rtl/pcihellocore_pulse_timer.sv
// One-shot pulse timer: a start in IDLE loads max(len,1) and holds busy for
// exactly that many cycles; starts while busy are ignored.
module pcihellocore_pulse_timer
  import pcihellocore_pio_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic [LEN_WIDTH-1:0] count,
  output pulse_state_e         state_dbg
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  pulse_state_e         state_q, state_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PULSE;
          count_d = (len == '0) ? LEN_ONE : len;
        end
      end
      ST_PULSE: begin
        // The cycle that sees count==1 is the last busy cycle.
        if (count_q == LEN_ONE) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - LEN_ONE;
        end
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_PULSE);
    count     = count_q;
    state_dbg = state_q;
  end

endmodule

// File: rtl/pcihellocore_pio_out.sv
// Avalon-MM PIO output port with set/clear aliases and a timed XOR pulse
// overlay on the output pins.
module pcihellocore_pio_out
  import pcihellocore_pio_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter int          LEN_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port
);

  // Bus handshake: a write is accepted on every edge where chipselect is high
  // and write_n is low; there is no waitrequest, reads are always valid one
  // cycle after the address is presented.
  logic                 wr_en;
  logic [31:0]          data_q, data_d;
  logic [LEN_WIDTH-1:0] plen_q, plen_d;
  logic [31:0]          mask_q, mask_d;
  logic [31:0]          rd_q, rd_d;
  logic                 start;
  logic                 busy;
  logic [LEN_WIDTH-1:0] count;
  pulse_state_e         timer_state;

  assign wr_en = chipselect & ~write_n;
  // A PULSE write while the timer runs must not relatch the mask.
  assign start = wr_en && (address == ADDR_PULSE) && (timer_state == ST_IDLE);

  pcihellocore_pulse_timer #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (plen_q),
    .busy      (busy),
    .count     (count),
    .state_dbg (timer_state)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      plen_q <= '0;
      mask_q <= '0;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      plen_q <= plen_d;
      mask_q <= mask_d;
      rd_q   <= rd_d;
    end
  end

  always_comb begin
    data_d = data_q;
    plen_d = plen_q;
    mask_d = mask_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:      data_d = writedata;
        ADDR_PULSE_LEN: plen_d = LEN_WIDTH'(writedata);
        ADDR_OUTSET:    data_d = data_q | writedata;
        ADDR_OUTCLEAR:  data_d = data_q & ~writedata;
        default:        data_d = data_q;
      endcase
    end
    if (start) begin
      mask_d = writedata;
    end
  end

  always_comb begin
    case (address)
      ADDR_DATA:      rd_d = data_q;
      ADDR_PULSE_LEN: rd_d = 32'(plen_q);
      ADDR_PULSE:     rd_d = mask_q;
      ADDR_STATUS:    rd_d = status_word(busy, 16'(count));
      default:        rd_d = '0;
    endcase
  end

  // The mask is gated by busy so the pins fall back to DATA the moment the
  // pulse ends, even though mask_q keeps its value for readback.
  assign out_port = data_q ^ (busy ? mask_q : 32'h0);
  assign readdata = rd_q;

endmodule

// File: tb/tb_pcihellocore_pio_out.sv
// Bench for pcihellocore_pio_out: directed scenarios with literal expectations
// plus randomized bus traffic checked every cycle against a behavioural model.
module tb_pcihellocore_pio_out;

  localparam logic [31:0] RV = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [31:0] out_port;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  pcihellocore_pio_out #(
    .RESET_VALUE(RV),
    .LEN_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chipselect(chipselect),
    .write_n   (write_n),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_data = RV;
  logic [15:0] m_plen = 16'h0;
  logic [31:0] m_mask = 32'h0;
  int          m_left = 0;
  logic [31:0] m_rd   = 32'h0;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd2:    return {16'h0, m_plen};
      3'd6:    return m_mask;
      3'd7:    return {m_left[15:0], 15'b0, (m_left > 0)};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = RV;
      m_plen = 16'h0;
      m_mask = 32'h0;
      m_left = 0;
      m_rd   = 32'h0;
    end else begin
      logic wr;
      int   left_next;
      m_rd = model_read(address);
      wr = chipselect && !write_n;
      left_next = (m_left > 0) ? m_left - 1 : 0;
      if (wr && address == 3'd6 && m_left == 0) begin
        m_mask    = writedata;
        left_next = (m_plen == 0) ? 1 : int'(m_plen);
      end
      if (wr) begin
        case (address)
          3'd0: m_data = writedata;
          3'd2: m_plen = writedata[15:0];
          3'd4: m_data = m_data | writedata;
          3'd5: m_data = m_data & ~writedata;
          default: ;
        endcase
      end
      m_left = left_next;
    end
  end

  // ---------------- continuous compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      logic [31:0] exp_out;
      exp_out = m_data ^ ((m_left > 0) ? m_mask : 32'h0);
      checks++;
      if (out_port !== exp_out) begin
        errors++;
        $display("FAIL model_out_port t=%0t got=%h exp=%h", $time, out_port, exp_out);
      end
      checks++;
      if (readdata !== m_rd) begin
        errors++;
        $display("FAIL model_readdata t=%0t got=%h exp=%h", $time, readdata, m_rd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset_n = 1'b0;
    step();
    step();
    check_en = 1'b1;
    check("reset_out_port", out_port, 32'h0000_00A5);
    check("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    step();

    // DATA write and readback
    bus_write(3'd0, 32'h1234_5678);
    check("data_out_port", out_port, 32'h1234_5678);
    address = 3'd0;
    step();
    check("data_readback", readdata, 32'h1234_5678);

    // set / clear
    bus_write(3'd0, 32'h0000_0F0F);
    bus_write(3'd4, 32'h0000_F000);
    check("outset", out_port, 32'h0000_FF0F);
    bus_write(3'd5, 32'h0000_000F);
    check("outclear", out_port, 32'h0000_FF00);
    address = 3'd4;
    step();
    check("read_outset", readdata, 32'h0);
    address = 3'd5;
    step();
    check("read_outclear", readdata, 32'h0);

    // pulse length 3
    bus_write(3'd0, 32'h0);
    bus_write(3'd2, 32'd3);
    bus_write(3'd6, 32'h1);
    check("pulse3_c1", out_port, 32'h1);
    address = 3'd7;
    step();
    check("pulse3_c2", out_port, 32'h1);
    check("status_3", readdata, 32'h0003_0001);
    step();
    check("pulse3_c3", out_port, 32'h1);
    check("status_2", readdata, 32'h0002_0001);
    step();
    check("pulse3_end", out_port, 32'h0);
    check("status_1", readdata, 32'h0001_0001);
    step();
    check("status_0", readdata, 32'h0);

    // zero length
    bus_write(3'd2, 32'd0);
    bus_write(3'd6, 32'h80);
    check("len0_c1", out_port, 32'h80);
    step();
    check("len0_end", out_port, 32'h0);

    // retrigger ignored
    bus_write(3'd2, 32'd10);
    bus_write(3'd6, 32'h1);
    step();
    step();
    bus_write(3'd6, 32'hFF);
    check("retrig_c4", out_port, 32'h1);
    for (int i = 5; i <= 10; i++) begin
      step();
      check($sformatf("retrig_c%0d", i), out_port, 32'h1);
    end
    step();
    check("retrig_end", out_port, 32'h0);
    address = 3'd6;
    step();
    check("mask_readback", readdata, 32'h1);

    // write DATA during pulse
    bus_write(3'd2, 32'd5);
    bus_write(3'd6, 32'h3);
    check("wdp_c1", out_port, 32'h3);
    step();
    check("wdp_c2", out_port, 32'h3);
    bus_write(3'd0, 32'h1);
    check("wdp_c3", out_port, 32'h2);
    step();
    check("wdp_c4", out_port, 32'h2);
    step();
    check("wdp_c5", out_port, 32'h2);
    step();
    check("wdp_end", out_port, 32'h1);

    // reset mid-pulse
    bus_write(3'd2, 32'd100);
    bus_write(3'd6, 32'hFFFF_0000);
    step();
    check("rst_pulse_on", out_port, 32'hFFFF_0001);
    reset_n = 1'b0;
    #1;
    check("rst_async_out", out_port, RV);
    check("rst_async_rd", readdata, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    address = 3'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_resume", out_port, RV);
    end
    check("rst_status", readdata, 32'h0);

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      r = $urandom();
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 1) == 1);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom();
      if (address == 3'd2) writedata = {r[31:16], 16'($urandom_range(0, 12))};
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      step();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    step();
    check_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
